// File: rtl/timer_datapath.sv
`default_nettype none
// ============================================================================
// Module   : timer_datapath
// Purpose  : Minute/second BCD countdown datapath for the egg timer. Loads
//            minutes or seconds from the switches, counts down once per
//            prescaled tick while enabled, reports zero to the controller and
//            blanks the display on a fixed cadence while flashing.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   TICK_DIV  - clock cycles per countdown tick (>= 2)
//   FLASH_DIV - clock cycles per display blank/unblank half-period (>= 2)
//   BEEP_DIV  - clock cycles per beep half-period (>= 2), used only with
//               the TIMER_BEEP_EN build option
// Ports:
//   clk          in   1  single clock, rising edge
//   reset        in   1  synchronous, active-high
//   valIn        in   8  BCD load value, [7:4] tens, [3:0] ones
//   timeWrtEn    in   1  write enable
//   initValEn    in   1  select valIn as write source
//   minEn        in   1  1 = write minutes, 0 = write seconds
//   decEn        in   1  countdown enable
//   flashEn      in   1  flash-display enable
//   minTens      out  4  minutes tens digit
//   minOnes      out  4  minutes ones digit
//   secTens      out  4  seconds tens digit
//   secOnes      out  4  seconds ones digit
//   isTimeFlat   out  1  all four digits are zero
//   displayBlank out  1  display driver blanks all digits
//   beep         out  1  audible square wave (0 without TIMER_BEEP_EN)
// Build option:
//   TIMER_BEEP_EN - when defined, builds the beep generator
// ============================================================================
module timer_datapath #(
  parameter int TICK_DIV  = 50000000,
  parameter int FLASH_DIV = 12500000,
  parameter int BEEP_DIV  = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] valIn,
  input  logic       timeWrtEn,
  input  logic       initValEn,
  input  logic       minEn,
  input  logic       decEn,
  input  logic       flashEn,
  output logic [3:0] minTens,
  output logic [3:0] minOnes,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       isTimeFlat,
  output logic       displayBlank,
  output logic       beep
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_DIV);
  localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] C_TICK_ONE   = TW'(1);
  localparam logic [FW-1:0] C_FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [FW-1:0] C_FLASH_ONE  = FW'(1);

  if (TICK_DIV < 2 || FLASH_DIV < 2 || BEEP_DIV < 2) begin : g_bad_params
    $error("timer_datapath: all divider parameters must be >= 2");
  end

  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [FW-1:0] blink_q, blink_d;
  logic          blank_q, blank_d;

  logic load;
  logic load_ok;
  logic tick;
  logic is_flat;

  assign is_flat = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                   (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  // Load, prescaler and countdown
  always_comb begin
    load    = timeWrtEn && initValEn;
    load_ok = minEn ? ((valIn[7:4] <= 4'd9) && (valIn[3:0] <= 4'd9))
                    : ((valIn[7:4] <= 4'd5) && (valIn[3:0] <= 4'd9));
    tick    = decEn && (presc_q == C_TICK_LAST);

    // Prescaler holds while paused so a pause keeps the partial second;
    // any load attempt restarts the second.
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (decEn) begin
      presc_d = tick ? '0 : presc_q + C_TICK_ONE;
    end

    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    if (load) begin
      // A load always beats a coincident tick; invalid values are ignored.
      if (load_ok) begin
        if (minEn) begin
          min_tens_d = valIn[7:4];
          min_ones_d = valIn[3:0];
        end else begin
          sec_tens_d = valIn[7:4];
          sec_ones_d = valIn[3:0];
        end
      end
    end else if (tick && !is_flat) begin
      // BCD borrow chain; minTens is never 0 when reached since not flat.
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) begin
            min_ones_d = min_ones_q - 4'd1;
          end else begin
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  // Flash cadence: blank toggles every FLASH_DIV cycles, first to 1.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if (!flashEn) begin
      blink_d = '0;
      blank_d = 1'b0;
    end else if (blink_q == C_FLASH_LAST) begin
      blink_d = '0;
      blank_d = ~blank_q;
    end else begin
      blink_d = blink_q + C_FLASH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      presc_q    <= '0;
      blink_q    <= '0;
      blank_q    <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
    end
  end

  assign minTens      = min_tens_q;
  assign minOnes      = min_ones_q;
  assign secTens      = sec_tens_q;
  assign secOnes      = sec_ones_q;
  assign isTimeFlat   = is_flat;
  assign displayBlank = blank_q;

`ifdef TIMER_BEEP_EN
  localparam int BW = $clog2(BEEP_DIV);
  localparam logic [BW-1:0] C_BEEP_LAST = BW'(BEEP_DIV - 1);
  localparam logic [BW-1:0] C_BEEP_ONE  = BW'(1);

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;

  // Tone sounds only during the visible half of the flash cadence.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    beep_d     = beep_q;
    if (!(flashEn && !blank_q)) begin
      beep_cnt_d = '0;
      beep_d     = 1'b0;
    end else if (beep_cnt_q == C_BEEP_LAST) begin
      beep_cnt_d = '0;
      beep_d     = ~beep_q;
    end else begin
      beep_cnt_d = beep_cnt_q + C_BEEP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_datapath
// Purpose  : Directed self-checking bench for timer_datapath with
//            TICK_DIV=4, FLASH_DIV=3, BEEP_DIV=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] valIn;
  logic       timeWrtEn;
  logic       initValEn;
  logic       minEn;
  logic       decEn;
  logic       flashEn;
  logic [3:0] minTens, minOnes, secTens, secOnes;
  logic       isTimeFlat;
  logic       displayBlank;
  logic       beep;

  int checks = 0;
  int errors = 0;

  timer_datapath #(
    .TICK_DIV (4),
    .FLASH_DIV(3),
    .BEEP_DIV (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valIn       (valIn),
    .timeWrtEn   (timeWrtEn),
    .initValEn   (initValEn),
    .minEn       (minEn),
    .decEn       (decEn),
    .flashEn     (flashEn),
    .minTens     (minTens),
    .minOnes     (minOnes),
    .secTens     (secTens),
    .secOnes     (secOnes),
    .isTimeFlat  (isTimeFlat),
    .displayBlank(displayBlank),
    .beep        (beep)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 ns later.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic is_min, input logic [7:0] v);
    timeWrtEn = 1'b1;
    initValEn = 1'b1;
    minEn     = is_min;
    valIn     = v;
    step(1);
    timeWrtEn = 1'b0;
    initValEn = 1'b0;
  endtask

  function automatic logic [15:0] digits();
    return {minTens, minOnes, secTens, secOnes};
  endfunction

  initial begin
    reset = 1'b1; valIn = 8'h00; timeWrtEn = 1'b0; initValEn = 1'b0;
    minEn = 1'b0; decEn = 1'b0; flashEn = 1'b0;
    step(2);
    reset = 1'b0;
    check("reset_digits", digits(), 16'h0000);
    check("reset_flat",  {15'd0, isTimeFlat}, 16'd1);
    check("reset_blank", {15'd0, displayBlank}, 16'd0);
    check("reset_beep",  {15'd0, beep}, 16'd0);

    // Basic load and countdown
    load(1'b1, 8'h01);
    check("load_min", digits(), 16'h0100);
    load(1'b0, 8'h02);
    check("load_sec", digits(), 16'h0102);
    check("flat_low", {15'd0, isTimeFlat}, 16'd0);
    decEn = 1'b1;
    step(3);
    check("pre_tick", digits(), 16'h0102);
    step(1);
    check("dec_4", digits(), 16'h0101);
    step(4);
    check("dec_8", digits(), 16'h0100);
    step(4);
    check("dec_12_borrow", digits(), 16'h0059);
    decEn = 1'b0;

    // Load validation
    load(1'b0, 8'h6A);
    check("rej_sec_6A", digits(), 16'h0059);
    load(1'b0, 8'h60);
    check("rej_sec_60", digits(), 16'h0059);
    load(1'b1, 8'h9A);
    check("rej_min_9A", digits(), 16'h0059);
    load(1'b1, 8'h99);
    load(1'b0, 8'h59);
    check("load_9959", digits(), 16'h9959);
    timeWrtEn = 1'b1; initValEn = 1'b0; minEn = 1'b1; valIn = 8'h11;
    step(1);
    timeWrtEn = 1'b0;
    check("wrt_no_init", digits(), 16'h9959);

    // Borrow across minutes tens
    load(1'b1, 8'h10);
    load(1'b0, 8'h00);
    decEn = 1'b1;
    step(4);
    check("dec_1000", digits(), 16'h0959);
    decEn = 1'b0;

    // Count to zero and stick
    load(1'b1, 8'h00);
    load(1'b0, 8'h01);
    check("load_0001", digits(), 16'h0001);
    decEn = 1'b1;
    step(3);
    check("pre_zero", digits(), 16'h0001);
    check("pre_zero_flat", {15'd0, isTimeFlat}, 16'd0);
    step(1);
    check("zero", digits(), 16'h0000);
    check("zero_flat", {15'd0, isTimeFlat}, 16'd1);
    step(8);
    check("no_wrap", digits(), 16'h0000);
    decEn = 1'b0;

    // Pause preserves partial second
    load(1'b0, 8'h05);
    decEn = 1'b1;
    step(2);
    decEn = 1'b0;
    step(10);
    check("paused", digits(), 16'h0005);
    decEn = 1'b1;
    step(1);
    check("resume_1", digits(), 16'h0005);
    step(1);
    check("resume_2", digits(), 16'h0004);
    decEn = 1'b0;

    // Flash cadence
    load(1'b0, 8'h00);
    flashEn = 1'b1;
    check("blank_0", {15'd0, displayBlank}, 16'd0);
    step(1); check("blank_1", {15'd0, displayBlank}, 16'd0);
    step(1); check("blank_2", {15'd0, displayBlank}, 16'd0);
`ifdef TIMER_BEEP_EN
    check("beep_on", {15'd0, beep}, 16'd1);
`else
    check("beep_tied", {15'd0, beep}, 16'd0);
`endif
    step(1); check("blank_3", {15'd0, displayBlank}, 16'd1);
    step(1); check("blank_4", {15'd0, displayBlank}, 16'd1);
`ifdef TIMER_BEEP_EN
    check("beep_blanked", {15'd0, beep}, 16'd0);
`endif
    step(1); check("blank_5", {15'd0, displayBlank}, 16'd1);
    step(1); check("blank_6", {15'd0, displayBlank}, 16'd0);
    step(3); check("blank_9", {15'd0, displayBlank}, 16'd1);
    flashEn = 1'b0;
    step(1); check("flash_off", {15'd0, displayBlank}, 16'd0);
    flashEn = 1'b1;
    step(2); check("reflash_2", {15'd0, displayBlank}, 16'd0);
    step(1); check("reflash_3", {15'd0, displayBlank}, 16'd1);
    flashEn = 1'b0;
    step(1);

    // Reset mid-countdown
    load(1'b0, 8'h30);
    decEn = 1'b1;
    flashEn = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    check("rst_digits", digits(), 16'h0000);
    check("rst_flat", {15'd0, isTimeFlat}, 16'd1);
    check("rst_blank", {15'd0, displayBlank}, 16'd0);
    reset = 1'b0;
    flashEn = 1'b0;
    decEn = 1'b0;

    // Load coincident with tick wins and restarts the second
    load(1'b0, 8'h09);
    decEn = 1'b1;
    step(3);
    timeWrtEn = 1'b1; initValEn = 1'b1; minEn = 1'b0; valIn = 8'h07;
    step(1);
    timeWrtEn = 1'b0; initValEn = 1'b0;
    check("load_on_tick", digits(), 16'h0007);
    step(3);
    check("tick_discarded", digits(), 16'h0007);
    step(1);
    check("after_reload", digits(), 16'h0006);
    decEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_datapath.md
# timer_datapath

Minute/second countdown datapath driven by the egg-timer control FSM's enable outputs. It loads BCD minute and second values from the switch input, decrements once per prescaled tick while enabled, and reports zero back to the controller on `isTimeFlat`. While flashing is enabled it blanks the display on a fixed cadence. It sits between the controller and the seven-segment display driver.

## Interface

Parameters:
- `TICK_DIV`, 50000000: clock cycles per countdown tick (1 s at 50 MHz); ≥2.
- `FLASH_DIV`, 12500000: clock cycles per display blank/unblank half-period; ≥2.
- `BEEP_DIV`, 25000: clock cycles per beep half-period; ≥2. Used only with `TIMER_BEEP_EN`.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `valIn` input 8: BCD load value; [7:4] tens digit, [3:0] ones digit.
- `timeWrtEn` input 1: write enable from controller.
- `initValEn` input 1: select `valIn` as write source.
- `minEn` input 1: 1 = write minutes, 0 = write seconds.
- `decEn` input 1: countdown enable.
- `flashEn` input 1: flash-display enable.
- `minTens`, `minOnes`, `secTens`, `secOnes` output 4 each: current time, BCD.
- `isTimeFlat` output 1: 1 when all four digits are zero.
- `displayBlank` output 1: 1 = display driver blanks all digits.
- `beep` output 1: audible square wave. Tied 0 without `TIMER_BEEP_EN`.

## Operation

- Load occurs when `timeWrtEn && initValEn`. With `timeWrtEn` alone, nothing happens.
- Minutes load (`minEn=1`): accepted if both digits ≤9.
- Seconds load (`minEn=0`): accepted if tens ≤5 and ones ≤9.
- An invalid load leaves the registers unchanged.
- Every load, valid or invalid, clears the prescaler.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only while `decEn=1`.
  - Holds its value while `decEn=0`, so a pause preserves the partial second.
  - Emits an internal `tick` on the cycle its count equals `TICK_DIV`-1, then wraps to 0.
- On `tick` with nonzero time, decrement by one second with BCD borrow:
  - secOnes 0→9 borrows from secTens.
  - secTens 0→5 borrows from minOnes.
  - minOnes 0→9 borrows from minTens.
  - Example: 10:00 → 09:59.
- On `tick` at 00:00: no change. No wrap to 99:59.
- `isTimeFlat` is decoded combinationally from the registered digits, with no added latency.
- Flash:
  - While `flashEn=1`, a blink counter toggles `displayBlank` every `FLASH_DIV` cycles. The first toggle is to 1, `FLASH_DIV` cycles after `flashEn` rises.
  - When `flashEn=0`, the blink counter is cleared and `displayBlank=0` on the next edge.
- Priority, highest first: `reset`, load, decrement. A load in the same cycle as `tick` wins, and that tick is discarded.
- `flashEn` and `decEn` are independent. Both may be high; the datapath does not check controller legality.

## Timing

- Reset values: all digits 0, `isTimeFlat`=1, `displayBlank`=0, `beep`=0, prescaler/blink/beep counters 0.
- Reset mid-countdown or mid-flash takes effect on the next edge and overrides all enables.
- Load latency: 1 cycle. Digits update on the edge where the write enables are sampled high.
- Decrement latency: digits change on the edge of the `tick` cycle, which is the `TICK_DIV`-th cycle of accumulated `decEn=1` after the last clear.
- `isTimeFlat` rises in the same cycle the digits become 00:00.

## Configuration

- `TIMER_BEEP_EN` defined:
  - While `flashEn=1` and `displayBlank=0`, `beep` toggles every `BEEP_DIV` cycles.
  - Otherwise `beep=0` and the beep counter is cleared.
- `TIMER_BEEP_EN` undefined: beep counter is not built and `beep` is constant 0.

## Test plan

Bench parameters: `TICK_DIV`=4, `FLASH_DIV`=3, `BEEP_DIV`=2.

- Reset, then load minutes `valIn`=8'h01 and seconds `valIn`=8'h02. Raise `decEn` → digits show 01:02, then 01:01 after 4 cycles, 01:00 after 8, 00:59 after 12.
- Load seconds 8'h6A → rejected, registers keep prior value. Load minutes 8'h9A → rejected. Load minutes 8'h99 plus seconds 8'h59 → 99:59.
- From 00:01 with `decEn=1`: after 4 cycles → 00:00, `isTimeFlat`=1. Continue 8 more cycles → digits remain 00:00.
- Pause: `decEn=1` for 2 cycles, `decEn=0` for 10 cycles, `decEn=1` again → decrement occurs after exactly 2 more cycles.
- Raise `flashEn` at 00:00 → `displayBlank` reads 0,0,0,1,1,1,0… Drop `flashEn` → `displayBlank`=0 the next cycle. With `TIMER_BEEP_EN`, `beep` toggles every 2 cycles only while unblanked.
- Assert `reset` during countdown at 00:30 → next cycle all digits 0, `isTimeFlat`=1. Assert a load coincident with `tick` → loaded value appears, no decrement.
